// File: rtl/cpu_types_pkg.sv
// Shared CPU types: machine word, fetch FSM states and PC step.
// No logic; pure declarations plus a word-alignment helper.
// No flow control of its own.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } fetch_state_t;

    localparam word_t PC_STEP = 32'd4;

    function automatic word_t word_align(input word_t addr);
        return addr & ~word_t'(3);
    endfunction

endpackage

// File: rtl/fetch_unit.sv
// Fetch driver: reads imem at pc_out, advances or redirects the PC, buffers one instruction for decode.
// Latency: instr_valid rises the cycle after ihit; pc_next/pcWEN/imemREN are combinational.
// Backpressure: imemREN drops while the buffer is full and id_ready is low. FETCH_STALL_COUNT_EN adds stall_count.
module fetch_unit
    import cpu_types_pkg::*;
#(
    parameter word_t PC_INIT = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        RST,
    input  word_t       pc_out,
    output word_t       pc_next,
    output logic        pcWEN,
    output logic        imemREN,
    output logic [31:0] imemaddr,
    input  logic        ihit,
    input  logic [31:0] imemload,
    output logic [31:0] instr_out,
    output logic [31:0] instr_pc,
    output logic        instr_valid,
    input  logic        id_ready,
    input  logic        redirect,
    input  logic [31:0] redirect_addr,
    input  logic        halt
`ifdef FETCH_STALL_COUNT_EN
    ,
    output logic [31:0] stall_count
`endif
);

    fetch_state_t state_q, state_d;
    logic         buffer_free;
    logic         redir_take;
    logic         accept;
    logic         consume;

    always_comb begin
        buffer_free = !instr_valid || id_ready;
        redir_take  = !RST && redirect && (state_q != HALTED);
        imemREN     = !RST && (state_q == RUN) && buffer_free && !redirect;
        accept      = imemREN && ihit;
        consume     = instr_valid && id_ready;
        imemaddr    = pc_out;
    end

    always_comb begin
        state_d = state_q;
        pcWEN   = 1'b0;
        pc_next = pc_out;
        if (RST) begin
            pc_next = PC_INIT;
        end else begin
            // Redirect outranks accept; imemREN already excludes the overlap in RUN.
            if (redir_take) begin
                pcWEN   = 1'b1;
                pc_next = word_align(redirect_addr);
            end else if (accept) begin
                pcWEN   = 1'b1;
                pc_next = pc_out + PC_STEP;
            end
            case (state_q)
                RUN: begin
                    if (!redir_take && halt)
                        state_d = (instr_valid && !id_ready) ? DRAIN : HALTED;
                end
                DRAIN: begin
                    if (redir_take || consume || !instr_valid)
                        state_d = HALTED;
                end
                HALTED:  state_d = HALTED;
                default: state_d = RUN;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST)
            state_q <= RUN;
        else
            state_q <= state_d;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            instr_out   <= '0;
            instr_pc    <= '0;
            instr_valid <= 1'b0;
        end else if (redir_take) begin
            instr_valid <= 1'b0;
        end else if (accept) begin
            instr_out   <= imemload;
            instr_pc    <= pc_out;
            instr_valid <= 1'b1;
        end else if (consume) begin
            instr_valid <= 1'b0;
        end
    end

`ifdef FETCH_STALL_COUNT_EN
    always_ff @(posedge CLK) begin
        if (RST)
            stall_count <= '0;
        else if (imemREN && !ihit && (stall_count != 32'hFFFF_FFFF))
            stall_count <= stall_count + 32'd1;
    end
`endif

endmodule
